noc_axi4_bridge_deser: RTL and testbench
========================================

NOC_AXI4_BRIDGE_DESER -- requirements
Module: noc_axi4_bridge_deser

Interface
REQ-001 SHALL have parameter SWAP_ENDIANESS, default 0, meaning reverse byte order within each 64-bit payload flit when 1.
REQ-002 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port flit_in  input  NOC_DATA_WIDTH (64)  NoC request flit.
REQ-005 SHALL have port flit_in_val  input  1  flit valid.
REQ-006 SHALL have port flit_in_rdy  output  1  flit accepted when val&rdy.
REQ-007 SHALL have port header_out  output  MSG_HEADER_WIDTH (192)  three header flits; flit0 in bits [63:0].
REQ-008 SHALL have port data_out  output  AXI4_DATA_WIDTH (512)  payload; payload flit k in bits [64k+63:64k].
REQ-009 SHALL have port out_val  output  1  packet complete.
REQ-010 SHALL have port out_rdy  input  1  downstream (AXI side) accepts when val&rdy.

Function
REQ-011 SHALL implement states HDR, DATA, SEND.
REQ-012 In HDR, flit_in_rdy=1; a 2-bit header counter advances 0..2 per accepted flit; flit n is stored at header_out[64n+63:64n].
REQ-013 On accepting flit0, data_out SHALL be cleared to 0 and payload count latched as MSG_LENGTH(flit0) minus 2, saturating at 0.
REQ-014 On accepting header flit 2: payload count 0 -> SEND; else -> DATA.
REQ-015 In DATA, flit_in_rdy=1; each accepted flit writes slot k (k=0..7) and decrements the count; accepting the last flit -> SEND.
REQ-016 Payload flits beyond 8 (k>=8) SHALL be accepted and discarded, with no data_out change; the FSM still waits for the full count.
REQ-017 In SEND, out_val=1 and flit_in_rdy=0; header_out and data_out SHALL hold stable until out_val&out_rdy.
REQ-018 out_val SHALL rise the cycle after the last flit of a packet is accepted (latency 1); on out_val&out_rdy the next state is HDR, and flit_in_rdy=1 in the following cycle.
REQ-019 flit_in_val low in HDR or DATA SHALL stall with no state change; gaps between flits are allowed.
REQ-020 With SWAP_ENDIANESS=1, each payload flit SHALL be byte-reversed before storage; header flits are never swapped.
REQ-021 MSG_LENGTH is 8 bits; count arithmetic SHALL not wrap below 0.

Reset
REQ-022 With rst high at a clock edge: state=HDR, counters=0, out_val=0, flit_in_rdy=0 during reset; header_out and data_out=0.
REQ-023 Reset mid-packet SHALL discard the partial packet; the first flit after reset is treated as flit0.

Configuration
REQ-024 With macro NOC_AXI4_BRIDGE_DESER_STRB_EN defined, the block SHALL add output strb_out (AXI4_DATA_WIDTH/8 = 64 bits), valid with out_val, holding 2^size_log set bits starting at byte offset addr[5:0] aligned down to 2^size_log.
REQ-025 strb_out SHALL be all-ones for MSG_TYPE_STORE_MEM and 0 when the payload count is 0.
REQ-026 Without the macro, strb_out and its logic SHALL be absent; all other behaviour is unchanged.

Structure
REQ-027 The state encoding, MAX_PAYLOAD_FLITS=8 and the header-counter width SHALL live in the shared bridge package alongside the existing MSG_* and AXI4_* definitions.
REQ-028 Size and offset SHALL come from the existing noc_extractSize applied to header_out.
REQ-029 Strobe generation SHALL be a single sub-module, noc_axi4_bridge_strb_gen, instantiated only under NOC_AXI4_BRIDGE_DESER_STRB_EN.

Verification
REQ-030 Load: 3 flits, MSG_LENGTH=2, back-to-back valid -> out_val in cycle 4, data_out=0, header_out matches the 3 flits.
REQ-031 Store: MSG_LENGTH=10, payload 0x0..0x7 -> data_out slot k=k, out_val 1 cycle after flit 11; with STRB_EN, strb_out=all-ones.
REQ-032 out_rdy held low 5 cycles in SEND -> outputs stable, flit_in_rdy=0 throughout, no flit lost.
REQ-033 MSG_LENGTH=12 (10 payload flits) -> slots hold flits 0..7, flits 8..9 discarded, one out_val.
REQ-034 SWAP_ENDIANESS=1, payload flit 0x0011223344556677 -> slot0=0x7766554433221100.
REQ-035 rst pulsed after 2 payload flits, then a new MSG_LENGTH=2 packet -> only the new header is reported, data_out=0.

Source files
------------

// File: rtl/noc_axi4_bridge_pkg.sv
// Shared NoC/AXI4 bridge definitions: message field positions, widths, deserializer state
// encoding and helper functions used by the deserializer and its strobe generator.
package noc_axi4_bridge_pkg;

    localparam int unsigned NOC_DATA_WIDTH   = 64;
    localparam int unsigned MSG_HEADER_WIDTH = 192;
    localparam int unsigned AXI4_DATA_WIDTH  = 512;
    localparam int unsigned AXI4_STRB_WIDTH  = AXI4_DATA_WIDTH / 8;

    // Header field positions, counted across the concatenated three-flit header
    localparam int unsigned MSG_LENGTH_WIDTH    = 8;
    localparam int unsigned MSG_LENGTH_LO       = 22;
    localparam int unsigned MSG_LENGTH_HI       = 29;
    localparam int unsigned MSG_TYPE_WIDTH      = 8;
    localparam int unsigned MSG_TYPE_LO         = 14;
    localparam int unsigned MSG_TYPE_HI         = 21;
    localparam int unsigned MSG_ADDR_LO         = 64;
    localparam int unsigned MSG_ADDR_HI         = 111;
    localparam int unsigned MSG_DATA_SIZE_LO    = 112;
    localparam int unsigned MSG_DATA_SIZE_HI    = 114;

    localparam logic [MSG_TYPE_WIDTH-1:0] MSG_TYPE_LOAD_MEM  = 8'd19;
    localparam logic [MSG_TYPE_WIDTH-1:0] MSG_TYPE_STORE_MEM = 8'd20;

    localparam int unsigned HDR_FLITS         = 3;
    localparam int unsigned HDR_CNT_W         = 2;
    localparam int unsigned MAX_PAYLOAD_FLITS = 8;
    localparam int unsigned SLOT_W            = $clog2(MAX_PAYLOAD_FLITS + 1);
    localparam int unsigned SLOT_IDX_W        = $clog2(MAX_PAYLOAD_FLITS);
    localparam int unsigned FLIT_LOG2         = $clog2(NOC_DATA_WIDTH);

    typedef enum logic [1:0] {
        ST_HDR  = 2'd0,
        ST_DATA = 2'd1,
        ST_SEND = 2'd2
    } deser_state_e;

    typedef struct packed {
        logic [2:0] size_log;
        logic [5:0] offset;
    } noc_size_t;

    // Access size as log2(bytes), saturated at a full 64-byte line, and the aligned line offset
    function automatic noc_size_t noc_extractSize(input logic [MSG_HEADER_WIDTH-1:0] header);
        noc_size_t  r;
        logic [2:0] fld;
        logic [5:0] align;
        fld        = header[MSG_DATA_SIZE_HI:MSG_DATA_SIZE_LO];
        r.size_log = (fld > 3'd6) ? 3'd6 : fld;
        align      = (6'd1 << r.size_log) - 6'd1;
        r.offset   = header[MSG_ADDR_LO+5:MSG_ADDR_LO] & ~align;
        return r;
    endfunction

    function automatic logic [NOC_DATA_WIDTH-1:0] noc_bswap64(input logic [NOC_DATA_WIDTH-1:0] d);
        logic [NOC_DATA_WIDTH-1:0] r;
        for (int b = 0; b < 8; b++) begin
            r[8*b +: 8] = d[8*(7-b) +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/noc_axi4_bridge_deser_strb.sv
// Byte-strobe generator for the deserialized AXI4 write line (only built when
// NOC_AXI4_BRIDGE_DESER_STRB_EN is defined).
module noc_axi4_bridge_strb_gen
    import noc_axi4_bridge_pkg::*;
(
    input  logic [MSG_LENGTH_WIDTH-1:0] msg_len_i,
    input  logic [MSG_TYPE_WIDTH-1:0]   msg_type_i,
    input  noc_size_t                   size_i,
    output logic [AXI4_STRB_WIDTH-1:0]  strb_c_o
);

    logic [6:0]                 nbytes;
    logic [AXI4_STRB_WIDTH-1:0] span;

    // Contiguous run of 2^size_log bytes placed at the aligned offset
    always_comb begin
        nbytes   = 7'd1 << size_i.size_log;
        span     = (size_i.size_log >= 3'd6) ? '1
                 : ((AXI4_STRB_WIDTH'(1) << nbytes) - AXI4_STRB_WIDTH'(1));
        strb_c_o = span << size_i.offset;
        if (msg_len_i <= MSG_LENGTH_WIDTH'(HDR_FLITS - 1)) begin
            strb_c_o = '0;
        end else if (msg_type_i == MSG_TYPE_STORE_MEM) begin
            strb_c_o = '1;
        end
    end

endmodule

// File: rtl/noc_axi4_bridge_deser.sv
// NoC-to-AXI4 deserializer: collects three header flits and up to eight payload flits
// into one line. Optional byte strobes under NOC_AXI4_BRIDGE_DESER_STRB_EN.
module noc_axi4_bridge_deser
    import noc_axi4_bridge_pkg::*;
#(
    parameter bit SWAP_ENDIANESS = 1'b0
)
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NOC_DATA_WIDTH-1:0]   flit_in,
    input  logic                        flit_in_val,
    output logic                        flit_in_rdy,
    output logic [MSG_HEADER_WIDTH-1:0] header_out,
    output logic [AXI4_DATA_WIDTH-1:0]  data_out,
    output logic                        out_val,
    input  logic                        out_rdy
`ifdef NOC_AXI4_BRIDGE_DESER_STRB_EN
    ,
    output logic [AXI4_STRB_WIDTH-1:0]  strb_out
`endif
);

    deser_state_e                state_q,   state_d;
    logic [HDR_CNT_W-1:0]        hdr_cnt_q, hdr_cnt_d;
    logic [MSG_LENGTH_WIDTH-1:0] pay_cnt_q, pay_cnt_d;
    logic [SLOT_W-1:0]           slot_q,    slot_d;
    logic [MSG_HEADER_WIDTH-1:0] header_q,  header_d;
    logic [AXI4_DATA_WIDTH-1:0]  data_q,    data_d;
    logic                        out_val_q, out_val_d;
    logic                        rdy_q,     rdy_d;

    logic                        flit_acc_c;
    logic [NOC_DATA_WIDTH-1:0]   payload_c;
    logic [MSG_LENGTH_WIDTH-1:0] msg_len_c;

    assign flit_acc_c = flit_in_val && rdy_q;
    assign payload_c  = SWAP_ENDIANESS ? noc_bswap64(flit_in) : flit_in;
    assign msg_len_c  = flit_in[MSG_LENGTH_HI:MSG_LENGTH_LO];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_HDR;
            hdr_cnt_q <= '0;
            pay_cnt_q <= '0;
            slot_q    <= '0;
            header_q  <= '0;
            data_q    <= '0;
            out_val_q <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            hdr_cnt_q <= hdr_cnt_d;
            pay_cnt_q <= pay_cnt_d;
            slot_q    <= slot_d;
            header_q  <= header_d;
            data_q    <= data_d;
            out_val_q <= out_val_d;
            rdy_q     <= rdy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        hdr_cnt_d = hdr_cnt_q;
        pay_cnt_d = pay_cnt_q;
        slot_d    = slot_q;
        header_d  = header_q;
        data_d    = data_q;

        case (state_q)
            ST_HDR: begin
                if (flit_acc_c) begin
                    header_d[{hdr_cnt_q, FLIT_LOG2'(0)} +: NOC_DATA_WIDTH] = flit_in;
                    // Flit0 opens a new packet: clear the line and latch the payload length
                    if (hdr_cnt_q == '0) begin
                        data_d    = '0;
                        slot_d    = '0;
                        pay_cnt_d = (msg_len_c > MSG_LENGTH_WIDTH'(HDR_FLITS - 1))
                                  ? msg_len_c - MSG_LENGTH_WIDTH'(HDR_FLITS - 1)
                                  : '0;
                    end
                    if (hdr_cnt_q == HDR_CNT_W'(HDR_FLITS - 1)) begin
                        hdr_cnt_d = '0;
                        state_d   = (pay_cnt_q == '0) ? ST_SEND : ST_DATA;
                    end else begin
                        hdr_cnt_d = hdr_cnt_q + HDR_CNT_W'(1);
                    end
                end
            end

            ST_DATA: begin
                if (flit_acc_c) begin
                    // Flits past the last slot are consumed but dropped
                    if (slot_q < SLOT_W'(MAX_PAYLOAD_FLITS)) begin
                        data_d[{slot_q[SLOT_IDX_W-1:0], FLIT_LOG2'(0)} +: NOC_DATA_WIDTH] = payload_c;
                        slot_d = slot_q + SLOT_W'(1);
                    end
                    if (pay_cnt_q != '0) begin
                        pay_cnt_d = pay_cnt_q - MSG_LENGTH_WIDTH'(1);
                    end
                    if (pay_cnt_q <= MSG_LENGTH_WIDTH'(1)) begin
                        state_d = ST_SEND;
                    end
                end
            end

            ST_SEND: begin
                if (out_rdy) begin
                    state_d = ST_HDR;
                end
            end

            default: begin
                state_d = ST_HDR;
            end
        endcase

        out_val_d = (state_d == ST_SEND);
        rdy_d     = (state_d != ST_SEND);
    end

    assign flit_in_rdy = rdy_q;
    assign header_out  = header_q;
    assign data_out    = data_q;
    assign out_val     = out_val_q;

`ifdef NOC_AXI4_BRIDGE_DESER_STRB_EN
    noc_size_t                  size_c;
    logic [AXI4_STRB_WIDTH-1:0] strb_c;

    assign size_c = noc_extractSize(header_q);

    noc_axi4_bridge_strb_gen u_strb_gen (
        .msg_len_i  (header_q[MSG_LENGTH_HI:MSG_LENGTH_LO]),
        .msg_type_i (header_q[MSG_TYPE_HI:MSG_TYPE_LO]),
        .size_i     (size_c),
        .strb_c_o   (strb_c)
    );

    // Strobes are qualified by out_val; header_q is stable for the whole SEND phase
    assign strb_out = out_val_q ? strb_c : '0;
`else
    // Strobe path not built in this configuration
`endif

endmodule

// File: tb/tb_noc_axi4_bridge_deser.sv
// Scoreboard bench for noc_axi4_bridge_deser: a plain and a byte-swapping instance share
// one flit stream; expected lines are queued at drive time and compared at out_val.
module tb_noc_axi4_bridge_deser;

    localparam logic [7:0] TB_LOAD  = 8'd19;
    localparam logic [7:0] TB_STORE = 8'd20;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [63:0]  flit_in = '0;
    logic         flit_in_val = 1'b0;
    logic         out_rdy = 1'b0;

    logic         flit_in_rdy, flit_in_rdy_sw;
    logic [191:0] header_out, header_out_sw;
    logic [511:0] data_out, data_out_sw;
    logic         out_val, out_val_sw;
`ifdef NOC_AXI4_BRIDGE_DESER_STRB_EN
    logic [63:0]  strb_out, strb_out_sw;
`endif

    noc_axi4_bridge_deser #(.SWAP_ENDIANESS(1'b0)) dut (
        .clk(clk), .rst(rst), .flit_in(flit_in), .flit_in_val(flit_in_val),
        .flit_in_rdy(flit_in_rdy), .header_out(header_out), .data_out(data_out),
        .out_val(out_val), .out_rdy(out_rdy)
`ifdef NOC_AXI4_BRIDGE_DESER_STRB_EN
        , .strb_out(strb_out)
`endif
    );

    noc_axi4_bridge_deser #(.SWAP_ENDIANESS(1'b1)) dut_sw (
        .clk(clk), .rst(rst), .flit_in(flit_in), .flit_in_val(flit_in_val),
        .flit_in_rdy(flit_in_rdy_sw), .header_out(header_out_sw), .data_out(data_out_sw),
        .out_val(out_val_sw), .out_rdy(out_rdy)
`ifdef NOC_AXI4_BRIDGE_DESER_STRB_EN
        , .strb_out(strb_out_sw)
`endif
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [191:0] hdr;
        logic [511:0] data;
        logic [511:0] data_sw;
        logic [63:0]  strb;
        int           stall;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        cur;
    int          errors = 0;
    int          checks = 0;
    int          sent = 0;
    int          rcvd = 0;
    int unsigned last_acc_cyc = 0;
    logic [63:0] pay_buf [16];

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_swap(input logic [63:0] d);
        logic [63:0] r;
        r = {<<8{d}};
        return r;
    endfunction

    function automatic logic [63:0] ref_strb(input logic [7:0] len, input logic [7:0] mtype,
                                             input logic [5:0] a6, input logic [2:0] sz);
        logic [63:0] r;
        int nb, off, s;
        r = '0;
        if (len <= 8'd2) return r;
        if (mtype == TB_STORE) return '1;
        s   = (sz > 3'd6) ? 6 : int'(sz);
        nb  = 1 << s;
        off = (int'(a6) / nb) * nb;
        for (int b = 0; b < 64; b++) begin
            if (b >= off && b < off + nb) r[b] = 1'b1;
        end
        return r;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the flit was taken
    task automatic send_flit(input logic [63:0] f, input int gap);
        logic acc;
        flit_in_val = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        flit_in     = f;
        flit_in_val = 1'b1;
        for (int n = 0; ; n++) begin
            @(negedge clk);
            acc = flit_in_rdy;
            @(posedge clk);
            #1;
            if (acc) break;
            if (n >= 300) begin
                chk("flit_accept_timeout", 512'(acc), 512'(1));
                break;
            end
        end
        last_acc_cyc = cyc;
        flit_in_val  = 1'b0;
    endtask

    task automatic send_packet(input logic [7:0] len, input logic [7:0] mtype, input logic [47:0] addr,
                               input logic [2:0] size, input int max_gap, input int stall);
        logic [63:0] f0, f1, f2;
        exp_t        e;
        int          npay;
        f0 = {$urandom, $urandom};
        f0[29:22] = len;
        f0[21:14] = mtype;
        f1 = {$urandom, $urandom};
        f1[47:0]  = addr;
        f1[50:48] = size;
        f2 = {$urandom, $urandom};
        npay = (len > 8'd2) ? int'(len) - 2 : 0;
        e.hdr     = {f2, f1, f0};
        e.data    = '0;
        e.data_sw = '0;
        for (int k = 0; k < npay && k < 8; k++) begin
            e.data[64*k +: 64]    = pay_buf[k];
            e.data_sw[64*k +: 64] = ref_swap(pay_buf[k]);
        end
        e.strb  = ref_strb(len, mtype, addr[5:0], size);
        e.stall = stall;
        sb_q.push_back(e);
        sent++;
        send_flit(f0, (max_gap == 0) ? 0 : $urandom_range(max_gap, 0));
        send_flit(f1, (max_gap == 0) ? 0 : $urandom_range(max_gap, 0));
        send_flit(f2, (max_gap == 0) ? 0 : $urandom_range(max_gap, 0));
        for (int k = 0; k < npay; k++) begin
            send_flit(pay_buf[k % 16], (max_gap == 0) ? 0 : $urandom_range(max_gap, 0));
        end
    endtask

    task automatic fill_seq();
        for (int k = 0; k < 16; k++) pay_buf[k] = 64'(k);
    endtask

    task automatic fill_rand();
        for (int k = 0; k < 16; k++) pay_buf[k] = {$urandom, $urandom};
    endtask

    task automatic wait_drain();
        for (int n = 0; ; n++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !out_val) break;
            if (n >= 3000) begin
                chk("drain_timeout", 512'(sb_q.size()), 512'(0));
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Output monitor: pops one expectation per SEND phase and holds out_rdy low for its stall
    logic [191:0] snap_h;
    logic [511:0] snap_d;
    bit           in_send = 1'b0;
    int           send_cyc = 0;

    always @(negedge clk) begin
        if (rst) begin
            in_send = 1'b0;
            out_rdy = 1'b0;
        end else if (out_val) begin
            if (!in_send) begin
                in_send  = 1'b1;
                send_cyc = 0;
                snap_h   = header_out;
                snap_d   = data_out;
                chk("out_val_latency", 512'(cyc), 512'(last_acc_cyc));
                if (sb_q.size() == 0) begin
                    chk("spurious_out_val", 512'(out_val), 512'(0));
                    cur.stall = 0;
                end else begin
                    cur = sb_q.pop_front();
                    rcvd++;
                    chk("header", 512'(header_out), 512'(cur.hdr));
                    chk("data", data_out, cur.data);
                    chk("sw_out_val", 512'(out_val_sw), 512'(1));
                    chk("sw_header", 512'(header_out_sw), 512'(cur.hdr));
                    chk("sw_data", data_out_sw, cur.data_sw);
`ifdef NOC_AXI4_BRIDGE_DESER_STRB_EN
                    chk("strb", 512'(strb_out), 512'(cur.strb));
                    chk("sw_strb", 512'(strb_out_sw), 512'(cur.strb));
`endif
                end
            end else begin
                chk("header_stable", 512'(header_out), 512'(snap_h));
                chk("data_stable", data_out, snap_d);
            end
            chk("in_rdy_in_send", 512'(flit_in_rdy), 512'(0));
            out_rdy  = (send_cyc >= cur.stall);
            send_cyc = send_cyc + 1;
        end else begin
            if (in_send) chk("val_held_until_rdy", 512'(out_rdy), 512'(1));
            in_send = 1'b0;
            out_rdy = 1'b0;
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_val", 512'(out_val), 512'(0));
        chk("rst_in_rdy", 512'(flit_in_rdy), 512'(0));
        chk("rst_header", 512'(header_out), 512'(0));
        chk("rst_data", data_out, 512'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        fill_seq();
        send_packet(8'd2, TB_LOAD, 48'h0000_1234_5640, 3'd3, 0, 0);
        send_packet(8'd10, TB_STORE, 48'h0000_0000_1000, 3'd6, 0, 0);
        fill_rand();
        send_packet(8'd4, TB_LOAD, 48'h0000_0abc_de13, 3'd2, 0, 5);
        fill_seq();
        send_packet(8'd12, TB_STORE, 48'h0000_0000_2000, 3'd6, 0, 0);
        fill_rand();
        pay_buf[0] = 64'h0011_2233_4455_6677;
        send_packet(8'd3, TB_LOAD, 48'h0000_0000_0008, 3'd3, 0, 0);
        send_packet(8'd0, TB_LOAD, 48'h0000_0000_0021, 3'd0, 0, 1);
        send_packet(8'd1, TB_LOAD, 48'h0000_0000_0030, 3'd4, 0, 0);
        send_packet(8'd5, TB_LOAD, 48'h0000_0000_0036, 3'd7, 2, 2);

        for (int i = 0; i < 10; i++) begin
            fill_rand();
            send_packet(8'($urandom_range(14, 0)), ($urandom_range(1, 0) == 0) ? TB_LOAD : TB_STORE,
                        {16'h0, $urandom}, 3'($urandom_range(7, 0)), 3, $urandom_range(3, 0));
        end
        wait_drain();

        // Partial packet killed by reset: never reported
        fill_rand();
        send_flit(64'h0000_0000_0300_0000, 0);
        send_flit({$urandom, $urandom}, 0);
        send_flit({$urandom, $urandom}, 0);
        send_flit(pay_buf[0], 0);
        send_flit(pay_buf[1], 0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_out_val", 512'(out_val), 512'(0));
        chk("midrst_in_rdy", 512'(flit_in_rdy), 512'(0));
        chk("midrst_header", 512'(header_out), 512'(0));
        chk("midrst_data", data_out, 512'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_packet(8'd2, TB_LOAD, 48'h0000_0000_0040, 3'd1, 0, 0);
        fill_seq();
        send_packet(8'd6, TB_STORE, 48'h0000_0000_0080, 3'd5, 1, 1);
        wait_drain();

        chk("pkts_received", 512'(rcvd), 512'(sent));
        chk("sb_empty", 512'(sb_q.size()), 512'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
